// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column strobe, 2-flop row sync, press/release debounce, key-code FIFO.
// Define KEYPAD_AUTOREPEAT_EN to re-push a held key every REPEAT_CYC cycles.
module keypad_scan_fifo #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 5000,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned REPEAT_CYC = 50000,
    localparam int unsigned CODE_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   fila,
    output logic [COLS-1:0]   columna,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CNT_W-1:0]  fill,
    output logic              overflow
);
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    if (ROWS == 0 || COLS == 0 || SCAN_DIV == 0 || DEB_CYCLES == 0 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || REPEAT_CYC == 0) begin : g_bad_param
        $error("keypad_scan_fifo: invalid parameter");
    end

    typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

    logic [ROWS-1:0]   sync1_q, rows_q;
    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_inc;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic [ROWS-1:0]   pat_q, pat_d;
    logic              push_req;
    logic [CODE_W-1:0] push_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            rows_q  <= '0;
        end else begin
            sync1_q <= fila;
            rows_q  <= sync1_q;
        end
    end

    assign col_inc = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);

    // Lowest set row of the latched pattern wins on multi-key presses.
    always_comb begin
        int unsigned r;
        r = 0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (pat_q[i]) r = i;
        end
        push_code = CODE_W'(r * COLS + int'(col_q));
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_live_q, rep_live_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q  <= '0;
            rep_live_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_live_q <= rep_live_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        push_req   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_live_d = rep_live_q;
`endif
        case (state_q)
            StScan: begin
                if (rows_q != '0) begin
                    pat_d   = rows_q;
                    cnt_d   = '0;
                    state_d = StDebounce;
                end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                    scan_cnt_d = '0;
                    col_d      = col_inc;
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            StDebounce: begin
                if (rows_q != pat_q) begin
                    state_d    = StScan;
                    scan_cnt_d = '0;
                    cnt_d      = '0;
                end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    push_req = 1'b1;
                    state_d  = StHold;
                    cnt_d    = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_d  = '0;
                    rep_live_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            StHold: begin
                if (rows_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    state_d    = StScan;
                    col_d      = col_inc;
                    scan_cnt_d = '0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                // Any deviation from the debounced pattern ends repeat until the next press.
                if (rep_live_q) begin
                    if (rows_q != pat_q) begin
                        rep_live_d = 1'b0;
                    end else if (rep_cnt_q == REP_W'(REPEAT_CYC - 1)) begin
                        push_req  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
`endif
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StScan;
            col_q      <= '0;
            scan_cnt_q <= '0;
            cnt_q      <= '0;
            pat_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            scan_cnt_q <= scan_cnt_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
        end
    end

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q, rd_next;
    logic [CNT_W-1:0]  fill_q, fill_d, remaining;
    logic [CODE_W-1:0] head_q, head_d;
    logic              ovf_q, full, do_pop, do_push;

    assign full      = (fill_q == CNT_W'(DEPTH));
    assign do_pop    = (fill_q != '0) && key_ready;
    assign do_push   = push_req && (!full || do_pop);
    assign rd_next   = rd_q + PTR_W'(do_pop);
    assign remaining = fill_q - CNT_W'(do_pop);
    assign fill_d    = remaining + CNT_W'(do_push);

    // Registered head: shows the pushed code when it lands in an empty queue, holds when drained.
    always_comb begin
        head_d = head_q;
        if (do_push && remaining == '0) begin
            head_d = push_code;
        end else if (do_pop && remaining != '0) begin
            head_d = mem_q[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_q + PTR_W'(do_push);
            rd_q   <= rd_next;
            fill_q <= fill_d;
            head_q <= head_d;
            if (push_req && full && !do_pop) ovf_q <= 1'b1;
        end
    end

    assign columna   = COLS'(1) << col_q;
    assign key_code  = head_q;
    assign key_valid = (fill_q != '0);
    assign fill      = fill_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: ROWS=4 COLS=4 SCAN_DIV=4 DEB_CYCLES=8 DEPTH=4 REPEAT_CYC=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_keypad_scan_fifo;
    localparam int unsigned DEB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] fill;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int row;
        int col;
        int code;
    } press_t;

    press_t tbl [5];

    keypad_scan_fifo #(
        .ROWS      (4),
        .COLS      (4),
        .SCAN_DIV  (4),
        .DEB_CYCLES(DEB),
        .DEPTH     (4),
        .REPEAT_CYC(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fila     (fila),
        .columna  (columna),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .fill     (fill),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_columna"}, 32'(columna), 32'd1);
        check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_fill"}, 32'(fill), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_key_code"}, 32'(key_code), 32'd0);
    endtask

    // Wait (bounded) for the strobe to move onto column col.
    task automatic wait_col(input int col);
        logic [3:0] prev;
        logic [3:0] target;
        logic       found;
        prev   = columna;
        target = 4'(1 << col);
        found  = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (columna == target && prev != target) found = 1'b1;
            prev = columna;
        end
        check("wait_col_reached", 32'(found), 32'd1);
    endtask

    task automatic press(input int row, input int col, input int hold);
        wait_col(col);
        fila = 4'(1 << row);
        cyc(hold);
        fila = 4'b0;
        cyc(DEB + 4);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        int exp_rep;

        tbl[0] = '{row: 0, col: 0, code: 0};
        tbl[1] = '{row: 1, col: 1, code: 5};
        tbl[2] = '{row: 2, col: 2, code: 10};
        tbl[3] = '{row: 3, col: 3, code: 15};
        tbl[4] = '{row: 1, col: 0, code: 4};

        // 1: reset and column rotation
        rst       = 1'b1;
        fila      = 4'b0;
        key_ready = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("rotate_columna", 32'(columna), 32'(1 << ((i / 4) % 4)));
            @(negedge clk);
        end

        // 2: single press, row 2 on column 1
        press(2, 1, 20);
        check("press_key_valid", 32'(key_valid), 32'd1);
        check("press_key_code", 32'(key_code), 32'd9);
        check("press_fill", 32'(fill), 32'd1);
        check("press_resume_col", 32'(columna), 32'b0100);
        pop_one();
        check("pop_key_valid", 32'(key_valid), 32'd0);
        check("pop_fill", 32'(fill), 32'd0);
        check("empty_holds_code", 32'(key_code), 32'd9);

        // 3: bounce on column 3, row 2
        wait_col(3);
        fila = 4'b0100;
        cyc(5);
        fila = 4'b0;
        cyc(2);
        fila = 4'b0100;
        cyc(4);
        check("bounce_no_early_push", 32'(fill), 32'd0);
        cyc(16);
        fila = 4'b0;
        cyc(DEB + 4);
        check("bounce_fill", 32'(fill), 32'd1);
        check("bounce_key_code", 32'(key_code), 32'd11);
        pop_one();
        check("bounce_pop_valid", 32'(key_valid), 32'd0);

        // 4: five presses into a 4-deep FIFO, then drain in order
        for (int i = 0; i < 5; i++) press(tbl[i].row, tbl[i].col, 20);
        check("full_fill", 32'(fill), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_head", 32'(key_code), 32'(tbl[0].code));
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_code", 32'(key_code), 32'(tbl[i].code));
            check("drain_valid", 32'(key_valid), 32'd1);
            @(negedge clk);
        end
        key_ready = 1'b0;
        check("drained_valid", 32'(key_valid), 32'd0);
        check("drained_fill", 32'(fill), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // 5: push and pop on the same edge while full
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("reset2_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) press(tbl[i].row, tbl[i].col, 20);
        check("refill_fill", 32'(fill), 32'd4);
        wait_col(0);
        fila = 4'b0010;
        cyc(10);                // push lands on the 11th rising edge after the press
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        check("pushpop_fill", 32'(fill), 32'd4);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_head", 32'(key_code), 32'd5);
        cyc(9);
        fila = 4'b0;
        cyc(DEB + 4);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", 32'(key_code), 32'((i < 3) ? tbl[i + 1].code : tbl[4].code));
            pop_one();
        end
        check("pushpop_drained", 32'(key_valid), 32'd0);

        // 5b: reset in the middle of debounce
        wait_col(1);
        fila = 4'b0010;
        cyc(6);
        rst = 1'b1;
        cyc(2);
        fila = 4'b0;
        check_reset_outputs("midreset");
        rst = 1'b0;
        cyc(20);
        check("midreset_no_push_fill", 32'(fill), 32'd0);
        check("midreset_no_push_valid", 32'(key_valid), 32'd0);

        // 6: long hold on column 0, row 0
        rst = 1'b1;
        cyc(1);
        rst  = 1'b0;
        fila = 4'b0001;
        cyc(110);
        fila = 4'b0;
        cyc(DEB + 4);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        check("hold_push_count", 32'(fill), 32'(exp_rep));
        check("hold_key_code", 32'(key_code), 32'd0);
        check("hold_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
